packet_interval_timer: RTL and testbench
========================================

Name: packet_interval_timer

Overview:
Parametrised packet-interval scheduler for the BLE FSK transmit path. Counts a programmable packet period gated by PLL lock. Raises countDone after a programmable guard interval. Issues one transmit request per period through a req/ack/done handshake, in continuous or fixed-length burst mode, and flags overruns when the modulator has not finished by the next period tick.

Parameters:
WAIT_SIZE, 24, width of interval counter, period and guard inputs
CNT_SIZE, 8, width of burst length and packet counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clkLock  in  1  PLL lock; low forces the same state as rst
enable  in  1  run request; rising edge starts a sequence
period  in  WAIT_SIZE  interval length in cycles; values 0/1 are treated as 2
guard  in  WAIT_SIZE  countDone asserts once waitcount > guard
burstLen  in  CNT_SIZE  packets per burst; 0 = continuous
txReq  out  1  transmit request, held until acknowledged
txAck  in  1  modulator accepted the request
txDone  in  1  one-cycle pulse: packet finished on air
countDone  out  1  guard elapsed in current interval
busy  out  1  state != IDLE
burstDone  out  1  one-cycle pulse: last burst packet completed
overrun  out  1  sticky: a period tick occurred while in REQ or TX
pktCount  out  CNT_SIZE  packets completed in current sequence

Behaviour:
- Reset (rst=1 or clkLock=0, sampled at posedge clk): state IDLE, waitcount=0, all outputs 0, pktCount=0, latched period/guard/burstLen cleared.
- States: IDLE, ARMED, REQ, TX.
- IDLE: waitcount held at 0. A rising edge of enable (enable=1 with previous-cycle enable=0) does the following:
  - latches period (clamped to >=2), guard and burstLen;
  - clears overrun and pktCount;
  - moves to ARMED with waitcount=0.
- Interval counter (any non-IDLE state): waitcount increments each cycle. When waitcount == latched period, waitcount wraps to 0 and a tick occurs. The interval is therefore period+1 cycles. New period/guard values are latched only at a tick.
- countDone is registered and equals 1 in the cycle after waitcount > guard. It returns to 0 the cycle after the wrap. It is always 0 in IDLE. If guard >= period, countDone never asserts.
- ARMED, on tick: go to REQ; txReq=1 from the next cycle.
- REQ: txReq stays high until txAck=1 is sampled. Then txReq=0 and the state moves to TX on the next cycle. txDone is ignored in REQ.
- TX, on txDone:
  - pktCount increments;
  - if burstLen != 0 and the new pktCount == burstLen: burstDone pulses for 1 cycle and the state goes to IDLE;
  - otherwise the state goes to ARMED.
- Overrun: a tick while in REQ or TX sets overrun (sticky) and is otherwise dropped. No queued request results from it.
- Simultaneous tick and txDone in TX: txDone is processed, the state goes to ARMED, and overrun is set. The request waits for the next tick.
- enable=0:
  - in ARMED: go to IDLE next cycle;
  - in REQ or TX: the handshake completes normally, then the state goes to IDLE instead of ARMED, with no burstDone unless the burst length was reached.
- pktCount saturates at all-ones in continuous mode.
- busy is registered and is 1 in every state except IDLE.

Test Plan:
- Reset/lock: hold clkLock=0 with enable=1 for 20 cycles -> all outputs 0; raise clkLock, then pulse enable -> busy=1 next cycle.
- Guard timing: period=100, guard=50, burstLen=0, txAck tied to txReq, txDone 10 cycles after ack -> countDone rises at waitcount 52 (registered) and falls after wrap; txReq rises every 101 cycles.
- Burst: period=200, burstLen=3, prompt ack/done -> exactly 3 txReq pulses, pktCount=3, burstDone single pulse, then IDLE, busy=0.
- Overrun: period=20, txDone delayed 30 cycles after ack -> overrun=1 at the first tick in TX, that request dropped, next txReq one interval later; overrun clears on the next enable rising edge.
- Ack stall: hold txAck=0 for 5 cycles -> txReq stays high all 5 cycles, drops the cycle after txAck=1.
- Mid-op disable: deassert enable during TX -> txDone accepted, pktCount increments, state IDLE, no further txReq; period=0 input -> interval of 3 cycles.

Source files
------------

// File: rtl/packet_interval_timer_if.sv
// Handshake and control bundle between the packet scheduler and its host/modulator.
// master drives configuration and the modulator acks; slave is the scheduler itself.
interface packet_interval_timer_if #(
  parameter int WAIT_SIZE = 24,
  parameter int CNT_SIZE  = 8
);
  logic                 enable;
  logic [WAIT_SIZE-1:0] period;
  logic [WAIT_SIZE-1:0] guard;
  logic [CNT_SIZE-1:0]  burstLen;
  logic                 txReq;
  logic                 txAck;
  logic                 txDone;
  logic                 countDone;
  logic                 busy;
  logic                 burstDone;
  logic                 overrun;
  logic [CNT_SIZE-1:0]  pktCount;

  modport master (
    output enable, period, guard, burstLen, txAck, txDone,
    input  txReq, countDone, busy, burstDone, overrun, pktCount
  );

  modport slave (
    input  enable, period, guard, burstLen, txAck, txDone,
    output txReq, countDone, busy, burstDone, overrun, pktCount
  );
endinterface

// File: rtl/packet_interval_timer.sv
// Packet-interval scheduler: free-running interval counter gated by PLL lock,
// guard flag, one req/ack/done transmit handshake per interval, burst and overrun tracking.
module packet_interval_timer #(
  parameter int WAIT_SIZE = 24,
  parameter int CNT_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clkLock,
  packet_interval_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, REQ, TX} state_t;

  state_t               state_q, state_d;
  logic                 enable_prev_q;
  logic [WAIT_SIZE-1:0] waitcount_q, waitcount_d;
  logic [WAIT_SIZE-1:0] period_q, period_d;
  logic [WAIT_SIZE-1:0] guard_q, guard_d;
  logic [CNT_SIZE-1:0]  burst_len_q, burst_len_d;
  logic [CNT_SIZE-1:0]  pkt_count_q, pkt_count_d;
  logic                 count_done_q, count_done_d;
  logic                 tx_req_q, tx_req_d;
  logic                 busy_q, busy_d;
  logic                 burst_done_q, burst_done_d;
  logic                 overrun_q, overrun_d;

  logic                 sync_rst;
  logic                 start;
  logic                 tick;
  logic [WAIT_SIZE-1:0] period_clamped;
  logic [CNT_SIZE-1:0]  pkt_count_inc;

  assign sync_rst       = rst | ~clkLock;
  assign start          = bus.enable & ~enable_prev_q;
  assign tick           = (state_q != IDLE) && (waitcount_q == period_q);
  assign period_clamped = (bus.period < WAIT_SIZE'(2)) ? WAIT_SIZE'(2) : bus.period;
  assign pkt_count_inc  = (&pkt_count_q) ? pkt_count_q : pkt_count_q + CNT_SIZE'(1);

  always_comb begin
    state_d      = state_q;
    waitcount_d  = waitcount_q;
    period_d     = period_q;
    guard_d      = guard_q;
    burst_len_d  = burst_len_q;
    pkt_count_d  = pkt_count_q;
    overrun_d    = overrun_q;
    burst_done_d = 1'b0;

    if (state_q == IDLE) begin
      waitcount_d = '0;
      if (start) begin
        period_d    = period_clamped;
        guard_d     = bus.guard;
        burst_len_d = bus.burstLen;
        overrun_d   = 1'b0;
        pkt_count_d = '0;
        state_d     = ARMED;
      end
    end else begin
      // Timing parameters may only change on an interval boundary.
      if (tick) begin
        waitcount_d = '0;
        period_d    = period_clamped;
        guard_d     = bus.guard;
      end else begin
        waitcount_d = waitcount_q + WAIT_SIZE'(1);
      end

      case (state_q)
        ARMED: begin
          if (!bus.enable) begin
            state_d = IDLE;
          end else if (tick) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (tick) begin
            overrun_d = 1'b1;
          end
          if (bus.txAck) begin
            state_d = TX;
          end
        end
        TX: begin
          if (tick) begin
            overrun_d = 1'b1;
          end
          if (bus.txDone) begin
            pkt_count_d = pkt_count_inc;
            if ((burst_len_q != '0) && (pkt_count_inc == burst_len_q)) begin
              burst_done_d = 1'b1;
              state_d      = IDLE;
            end else if (!bus.enable) begin
              state_d = IDLE;
            end else begin
              state_d = ARMED;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
        waitcount_d = '0;
      end
    end

    // The wrap cycle itself clears the flag so it drops right after the interval ends.
    count_done_d = (state_d != IDLE) && !tick && (waitcount_q > guard_q);
    tx_req_d     = (state_d == REQ);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    enable_prev_q <= bus.enable;
    if (sync_rst) begin
      state_q      <= IDLE;
      waitcount_q  <= '0;
      period_q     <= '0;
      guard_q      <= '0;
      burst_len_q  <= '0;
      pkt_count_q  <= '0;
      count_done_q <= 1'b0;
      tx_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitcount_q  <= waitcount_d;
      period_q     <= period_d;
      guard_q      <= guard_d;
      burst_len_q  <= burst_len_d;
      pkt_count_q  <= pkt_count_d;
      count_done_q <= count_done_d;
      tx_req_q     <= tx_req_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.txReq     = tx_req_q;
  assign bus.countDone = count_done_q;
  assign bus.busy      = busy_q;
  assign bus.burstDone = burst_done_q;
  assign bus.overrun   = overrun_q;
  assign bus.pktCount  = pkt_count_q;

endmodule

// File: tb/tb_packet_interval_timer.sv
// Directed bench for packet_interval_timer: a scripted modulator acks/finishes requests
// while edge times of the outputs are logged and compared against hand-derived cycle counts.
module tb_packet_interval_timer;

  localparam int WAIT_SIZE = 24;
  localparam int CNT_SIZE  = 8;

  logic clk = 1'b0;
  logic rst;
  logic clkLock;

  packet_interval_timer_if #(.WAIT_SIZE(WAIT_SIZE), .CNT_SIZE(CNT_SIZE)) bus_if ();

  packet_interval_timer #(.WAIT_SIZE(WAIT_SIZE), .CNT_SIZE(CNT_SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .clkLock (clkLock),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int req_rises[$];
  int req_falls[$];
  int cd_rises[$];
  int cd_falls[$];
  int ov_rises[$];
  int bd_cycles;

  int done_cnt   = 0;
  int done_delay = 1;
  int stall_left = 0;
  logic prev_req = 1'b0;
  logic prev_cd  = 1'b0;
  logic prev_ov  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input int expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  function automatic int first_after(input int q[$], input int t);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] > t) return q[i];
    end
    return -100000;
  endfunction

  task automatic clear_log();
    req_rises.delete();
    req_falls.delete();
    cd_rises.delete();
    cd_falls.delete();
    ov_rises.delete();
    bd_cycles = 0;
  endtask

  // One clock: sample outputs 1 time unit after the edge, log edges, then play modulator.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus_if.txReq && !prev_req)     req_rises.push_back(cyc);
    if (!bus_if.txReq && prev_req)     req_falls.push_back(cyc);
    if (bus_if.countDone && !prev_cd)  cd_rises.push_back(cyc);
    if (!bus_if.countDone && prev_cd)  cd_falls.push_back(cyc);
    if (bus_if.overrun && !prev_ov)    ov_rises.push_back(cyc);
    if (bus_if.burstDone)              bd_cycles++;
    prev_req = bus_if.txReq;
    prev_cd  = bus_if.countDone;
    prev_ov  = bus_if.overrun;

    bus_if.txDone = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) bus_if.txDone = 1'b1;
    end
    if (bus_if.txReq) begin
      if (stall_left > 0) begin
        stall_left--;
        bus_if.txAck = 1'b0;
      end else begin
        bus_if.txAck = 1'b1;
        done_cnt     = done_delay;
      end
    end else begin
      bus_if.txAck = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int n0;
  int r0;

  initial begin
    rst             = 1'b1;
    clkLock         = 1'b0;
    bus_if.enable   = 1'b0;
    bus_if.period   = '0;
    bus_if.guard    = '0;
    bus_if.burstLen = '0;
    bus_if.txAck    = 1'b0;
    bus_if.txDone   = 1'b0;
    clear_log();
    run(3);

    // Lock low with enable high keeps everything in reset
    rst           = 1'b0;
    bus_if.enable = 1'b1;
    run(20);
    check_val("lock_txReq",     bus_if.txReq, 0);
    check_val("lock_countDone", bus_if.countDone, 0);
    check_val("lock_busy",      bus_if.busy, 0);
    check_val("lock_burstDone", bus_if.burstDone, 0);
    check_val("lock_overrun",   bus_if.overrun, 0);
    check_val("lock_pktCount",  bus_if.pktCount, 0);
    clkLock       = 1'b1;
    bus_if.enable = 1'b0;
    run(2);
    bus_if.enable = 1'b1;
    run(1);
    check_val("start_busy", bus_if.busy, 1);
    bus_if.enable = 1'b0;
    run(1);
    check_val("armed_disable_busy", bus_if.busy, 0);

    // Guard timing, continuous mode
    bus_if.period   = 24'd100;
    bus_if.guard    = 24'd50;
    bus_if.burstLen = 8'd0;
    done_delay      = 10;
    stall_left      = 0;
    clear_log();
    n0 = cyc;
    bus_if.enable = 1'b1;
    run(350);
    r0 = at(req_rises, 0);
    check_val("guard_first_req",  r0 - n0, 102);
    check_val("guard_req_int1",   at(req_rises, 1) - r0, 101);
    check_val("guard_req_int2",   at(req_rises, 2) - at(req_rises, 1), 101);
    check_val("guard_cd_rise",    first_after(cd_rises, r0) - r0, 52);
    check_val("guard_cd_fall",    first_after(cd_falls, r0) - r0, 101);
    check_val("guard_pktCount",   bus_if.pktCount, 3);
    check_val("guard_overrun",    bus_if.overrun, 0);
    bus_if.enable = 1'b0;
    run(5);
    check_val("guard_stop_busy",  bus_if.busy, 0);

    // Burst of three, guard == period so countDone must stay low
    bus_if.period   = 24'd200;
    bus_if.guard    = 24'd200;
    bus_if.burstLen = 8'd3;
    done_delay      = 1;
    clear_log();
    bus_if.enable = 1'b1;
    run(900);
    check_val("burst_req_count",  req_rises.size(), 3);
    check_val("burst_pktCount",   bus_if.pktCount, 3);
    check_val("burst_done_pulse", bd_cycles, 1);
    check_val("burst_busy",       bus_if.busy, 0);
    check_val("burst_cd_never",   cd_rises.size(), 0);
    bus_if.enable = 1'b0;
    run(1);

    // Overrun: modulator takes longer than one interval
    bus_if.period   = 24'd20;
    bus_if.guard    = 24'd5;
    bus_if.burstLen = 8'd0;
    done_delay      = 30;
    clear_log();
    n0 = cyc;
    bus_if.enable = 1'b1;
    run(90);
    r0 = at(req_rises, 0);
    check_val("ovr_first_req",   r0 - n0, 22);
    check_val("ovr_set_time",    at(ov_rises, 0) - r0, 21);
    check_val("ovr_next_req",    at(req_rises, 1) - r0, 42);
    check_val("ovr_sticky",      bus_if.overrun, 1);
    bus_if.enable = 1'b0;
    run(40);
    check_val("ovr_idle_busy",   bus_if.busy, 0);
    check_val("ovr_idle_pkt",    bus_if.pktCount, 2);
    check_val("ovr_idle_keep",   bus_if.overrun, 1);
    bus_if.enable = 1'b1;
    run(1);
    check_val("ovr_cleared",     bus_if.overrun, 0);
    check_val("ovr_pkt_cleared", bus_if.pktCount, 0);
    bus_if.enable = 1'b0;
    run(1);

    // period=0 clamps to 2: interval of 3 cycles
    bus_if.period = 24'd0;
    bus_if.guard  = 24'd0;
    done_delay    = 1;
    clear_log();
    n0 = cyc;
    bus_if.enable = 1'b1;
    run(20);
    r0 = at(req_rises, 0);
    check_val("p0_first_req", r0 - n0, 4);
    check_val("p0_int1",      at(req_rises, 1) - r0, 3);
    check_val("p0_int2",      at(req_rises, 2) - at(req_rises, 1), 3);
    check_val("p0_overrun",   bus_if.overrun, 0);
    bus_if.enable = 1'b0;
    run(10);
    check_val("p0_stop_busy", bus_if.busy, 0);

    // Ack stall of 5 cycles, then disable while in TX
    bus_if.period = 24'd50;
    done_delay    = 3;
    stall_left    = 5;
    clear_log();
    n0 = cyc;
    bus_if.enable = 1'b1;
    run(59);
    bus_if.enable = 1'b0;
    run(60);
    r0 = at(req_rises, 0);
    check_val("stall_first_req", r0 - n0, 52);
    check_val("stall_req_len",   at(req_falls, 0) - r0, 6);
    check_val("stall_req_count", req_rises.size(), 1);
    check_val("stall_pktCount",  bus_if.pktCount, 1);
    check_val("stall_busy",      bus_if.busy, 0);
    check_val("stall_no_bd",     bd_cycles, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
